// File: rtl/pwm_gen_pkg.sv
// Shared types and defaults for the pwm_gen multi-channel PWM generator.
package pwm_gen_pkg;

  localparam int PWM_W = 16;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  typedef struct packed {
    logic [PWM_W-1:0] duty;
    logic             pol;
  } pwm_ch_cfg_t;

endpackage

// File: rtl/pwm_gen_ch.sv
// One PWM channel: unsigned compare against the shared count, polarity and
// the registered output stage.
module pwm_gen_ch
  import pwm_gen_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         force_off_i,
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] duty_i,
  input  logic         pol_i,
  output logic         pwm_o
);

  logic raw;

  assign raw = !force_off_i && (cnt_i < duty_i);

  // Output follows the count one cycle late; clear parks it at its inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_o <= 1'b0;
    end else if (clr_i) begin
      pwm_o <= pol_i;
    end else if (en_i) begin
      pwm_o <= raw ^ pol_i;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator: shared edge/center-aligned time base with
// double-buffered configuration that only swaps in at period boundaries.
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int W = PWM_W,
  parameter int N = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                upd_i,
  input  logic                mode_i,
  input  logic [W-1:0]        period_i,
  input  logic [N-1:0][W-1:0] duty_i,
  input  logic [N-1:0]        pol_i,
  output logic [W-1:0]        cnt_o,
  output logic [N-1:0]        pwm_o,
  output logic                prd_o,
  output logic                upd_ack_o
);

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic [W-1:0]        cnt_q, cnt_d;
  pwm_dir_e            dir_q, dir_d;
  pwm_mode_e           act_mode_q, pend_mode_q;
  logic [W-1:0]        act_period_q, pend_period_q;
  logic [N-1:0][W-1:0] act_duty_q, pend_duty_q;
  logic [N-1:0]        act_pol_q, pend_pol_q;
  logic                pend_q;
  logic                ack_q;
  logic                period_zero;
  logic                boundary;
  logic                apply;

  // Reset asserts immediately but is released only after two clock edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n       = rst_sync_q[1];
  assign period_zero = (act_period_q == '0);

  // The >= / <= forms keep the counter sane if a period shrinks while paused.
  always_comb begin
    boundary = 1'b0;
    if (period_zero) begin
      boundary = 1'b1;
    end else if (act_mode_q == PWM_EDGE) begin
      boundary = (cnt_q >= act_period_q - W'(1));
    end else if (dir_q == DIR_DOWN) begin
      boundary = (cnt_q <= W'(1));
    end else begin
      boundary = (act_period_q == W'(1)) && (cnt_q != '0);
    end
  end

  assign apply = !clr_i && (pend_q || upd_i) && (!en_i || boundary);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (clr_i) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (en_i) begin
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (act_mode_q == PWM_EDGE) begin
        cnt_d = cnt_q + W'(1);
      end else if (dir_q == DIR_DOWN) begin
        cnt_d = cnt_q - W'(1);
      end else if (cnt_q >= act_period_q) begin
        cnt_d = cnt_q - W'(1);
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // An update arriving on a boundary (or while paused) skips the shadow stage.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= 1'b0;
      ack_q         <= 1'b0;
      act_mode_q    <= PWM_EDGE;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      act_pol_q     <= '0;
      pend_mode_q   <= PWM_EDGE;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_pol_q    <= '0;
    end else begin
      ack_q <= apply;
      if (clr_i) begin
        pend_q <= 1'b0;
      end else if (apply) begin
        pend_q <= 1'b0;
        if (upd_i) begin
          act_mode_q   <= pwm_mode_e'(mode_i);
          act_period_q <= period_i;
          act_duty_q   <= duty_i;
          act_pol_q    <= pol_i;
        end else begin
          act_mode_q   <= pend_mode_q;
          act_period_q <= pend_period_q;
          act_duty_q   <= pend_duty_q;
          act_pol_q    <= pend_pol_q;
        end
      end else if (upd_i) begin
        pend_q        <= 1'b1;
        pend_mode_q   <= pwm_mode_e'(mode_i);
        pend_period_q <= period_i;
        pend_duty_q   <= duty_i;
        pend_pol_q    <= pol_i;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    pwm_gen_ch #(
      .W(W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_n),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .force_off_i(period_zero),
      .cnt_i      (cnt_q),
      .duty_i     (act_duty_q[k]),
      .pol_i      (act_pol_q[k]),
      .pwm_o      (pwm_o[k])
    );
  end

  assign cnt_o     = cnt_q;
  assign prd_o     = rst_n && en_i && !clr_i && boundary;
  assign upd_ack_o = ack_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: a phase-based reference model predicts each cycle's
// outputs into a scoreboard queue that is drained as the DUT runs.
module tb_pwm_gen;
  import pwm_gen_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic [N-1:0] pwm;
    logic         prd;
    logic         ack;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b1;
  logic                en_i, clr_i, upd_i, mode_i;
  logic [W-1:0]        period_i;
  logic [N-1:0][W-1:0] duty_i;
  logic [N-1:0]        pol_i;
  logic [W-1:0]        cnt_o;
  logic [N-1:0]        pwm_o;
  logic                prd_o, upd_ack_o;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int           m_ph, m_p, m_pp;
  int           m_d[N];
  int           m_pd[N];
  logic         m_mode, m_pmode, m_pend, m_ack;
  logic [N-1:0] m_pol, m_ppol, m_pwm;

  pwm_gen #(.W(W), .N(N)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .upd_i    (upd_i),
    .mode_i   (mode_i),
    .period_i (period_i),
    .duty_i   (duty_i),
    .pol_i    (pol_i),
    .cnt_o    (cnt_o),
    .pwm_o    (pwm_o),
    .prd_o    (prd_o),
    .upd_ack_o(upd_ack_o)
  );

  always #5 clk_i = ~clk_i;

  // Period length in cycles; the count is a fold of the phase in center mode.
  function automatic int modelLen();
    if (m_p == 0) return 1;
    return m_mode ? 2 * m_p : m_p;
  endfunction

  function automatic int modelCnt();
    if (m_p == 0) return 0;
    if (!m_mode || m_ph <= m_p) return m_ph;
    return 2 * m_p - m_ph;
  endfunction

  task automatic modelReset();
    m_ph = 0; m_p = 0; m_pp = 0; m_mode = 1'b0; m_pmode = 1'b0;
    m_pend = 1'b0; m_ack = 1'b0; m_pol = '0; m_ppol = '0; m_pwm = '0;
    for (int k = 0; k < N; k++) begin
      m_d[k] = 0;
      m_pd[k] = 0;
    end
    sb_q.delete();
  endtask

  task automatic checkValue(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("[TB] FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    n_tests++;
    assert (cnt_o === e.cnt) else begin
      n_fail++;
      $error("[TB] FAIL %s cnt_o got %0d expected %0d", tag, cnt_o, e.cnt);
    end
    n_tests++;
    assert (pwm_o === e.pwm) else begin
      n_fail++;
      $error("[TB] FAIL %s pwm_o got %b expected %b", tag, pwm_o, e.pwm);
    end
    n_tests++;
    assert (prd_o === e.prd) else begin
      n_fail++;
      $error("[TB] FAIL %s prd_o got %b expected %b", tag, prd_o, e.prd);
    end
    n_tests++;
    assert (upd_ack_o === e.ack) else begin
      n_fail++;
      $error("[TB] FAIL %s upd_ack_o got %b expected %b", tag, upd_ack_o, e.ack);
    end
  endtask

  // Config pins change just after a clock edge so they never race a sample.
  task automatic setConfig(input logic m, input int p, input int d0, input int d1,
                           input int d2, input int d3, input logic [N-1:0] pol);
    @(posedge clk_i);
    #1;
    mode_i    = m;
    period_i  = W'(p);
    duty_i[0] = W'(d0);
    duty_i[1] = W'(d1);
    duty_i[2] = W'(d2);
    duty_i[3] = W'(d3);
    pol_i     = pol;
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic upd,
                               input string tag);
    exp_t         e;
    int           cnt_e;
    logic         bnd, apply;
    logic [N-1:0] raw;
    @(negedge clk_i);
    en_i  = en;
    clr_i = clr;
    upd_i = upd;
    cnt_e = modelCnt();
    bnd   = (m_ph == modelLen() - 1);
    e.cnt = W'(cnt_e);
    e.pwm = m_pwm;
    e.prd = en && !clr && bnd;
    e.ack = m_ack;
    sb_q.push_back(e);
    #2;
    checkOutput(tag);
    apply = !clr && (m_pend || upd) && (!en || bnd);
    for (int k = 0; k < N; k++) raw[k] = (cnt_e < m_d[k]);
    if (clr) m_pwm = m_pol;
    else if (en) m_pwm = (m_p == 0) ? m_pol : (raw ^ m_pol);
    if (clr) m_ph = 0;
    else if (en) m_ph = bnd ? 0 : m_ph + 1;
    m_ack = apply;
    if (clr) begin
      m_pend = 1'b0;
    end else if (apply) begin
      m_pend = 1'b0;
      if (upd) begin
        m_mode = mode_i; m_p = int'(period_i); m_pol = pol_i;
        for (int k = 0; k < N; k++) m_d[k] = int'(duty_i[k]);
      end else begin
        m_mode = m_pmode; m_p = m_pp; m_pol = m_ppol;
        for (int k = 0; k < N; k++) m_d[k] = m_pd[k];
      end
    end else if (upd) begin
      m_pend = 1'b1;
      m_pmode = mode_i; m_pp = int'(period_i); m_ppol = pol_i;
      for (int k = 0; k < N; k++) m_pd[k] = int'(duty_i[k]);
    end
  endtask

  task automatic applyReset(input string tag, input logic check_now);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    en_i   = 1'b1;
    clr_i  = 1'b0;
    upd_i  = 1'b0;
    #1;
    if (check_now) begin
      checkValue({tag, "_cnt_now"}, int'(cnt_o), 0);
      checkValue({tag, "_pwm_now"}, int'(pwm_o), 0);
      checkValue({tag, "_prd_now"}, int'(prd_o), 0);
      checkValue({tag, "_ack_now"}, int'(upd_ack_o), 0);
    end
    modelReset();
    repeat (2) @(negedge clk_i);
    #1;
    checkValue({tag, "_cnt"}, int'(cnt_o), 0);
    checkValue({tag, "_pwm"}, int'(pwm_o), 0);
    checkValue({tag, "_prd"}, int'(prd_o), 0);
    checkValue({tag, "_ack"}, int'(upd_ack_o), 0);
    en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, {tag, "_rel"});
  endtask

  initial begin
    int hi;
    int exp_hi;
    int c;
    en_i = 1'b0; clr_i = 1'b0; upd_i = 1'b0; mode_i = 1'b0;
    period_i = '0; duty_i = '0; pol_i = '0;
    modelReset();
    applyReset("rst0", 1'b0);

    // Edge mode, configured while paused so the update lands immediately.
    setConfig(1'b0, 10, 5, 0, 10, 3, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, "cfg_en0");
    applyStimulus(1'b0, 1'b0, 1'b0, "ack_en0");
    repeat (25) applyStimulus(1'b1, 1'b0, 1'b0, "edge");
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "edge_win");
      hi += int'(pwm_o[0]);
    end
    checkValue("edge_duty_hi", hi, 5);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "edge_prd");
      hi += int'(prd_o);
    end
    checkValue("edge_prd_cnt", hi, 2);

    // Mid-period duty change must wait for the current period to finish.
    setConfig(1'b0, 10, 2, 0, 10, 3, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_d2");
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, "run_d2");
    for (int i = 0; i < 20 && modelCnt() != 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, "seek4");
    setConfig(1'b0, 10, 7, 0, 10, 3, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_d7");
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "run_d7");
      hi += int'(upd_ack_o);
    end
    checkValue("mid_ack_once", hi, 1);

    // Update on the boundary cycle itself: the very next period is 4 long.
    for (int i = 0; i < 20 && modelCnt() != 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, "seek9");
    setConfig(1'b0, 4, 2, 0, 10, 3, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "bnd_upd");
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "p4");
      hi += int'(prd_o);
    end
    checkValue("bnd_p4_prd", hi, 2);

    // Center mode: count folds 0..P..1, so cnt<D holds for 2D-1 of 2P cycles.
    setConfig(1'b1, 8, 4, 0, 9, 8, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_center");
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, "center");
    exp_hi = 0;
    for (int ph = 0; ph < 16; ph++) begin
      c = (ph <= 8) ? ph : 16 - ph;
      if (c < 4) exp_hi++;
    end
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "center_win");
      hi += int'(pwm_o[0]);
    end
    checkValue("center_duty_hi", hi, exp_hi);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "center_prd");
      hi += int'(prd_o);
    end
    checkValue("center_prd_cnt", hi, 1);

    // Clear with a simultaneous update: time base restarts, config untouched.
    setConfig(1'b0, 10, 5, 0, 10, 3, 4'b1000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_pol3");
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, "pol3");
    for (int i = 0; i < 20 && modelCnt() != 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "seek6");
    setConfig(1'b0, 5, 1, 1, 1, 1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b1, "clr_upd");
    applyStimulus(1'b1, 1'b0, 1'b0, "after_clr");
    checkValue("clr_cnt", int'(cnt_o), 0);
    checkValue("clr_pwm3", int'(pwm_o[3]), 1);
    checkValue("clr_no_ack", int'(upd_ack_o), 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "post_clr");
      hi += int'(prd_o) + int'(upd_ack_o);
    end
    checkValue("clr_cfg_kept", hi, 1);

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "hold");
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, "resume");

    // Zero period: outputs parked at polarity, every cycle is a boundary.
    setConfig(1'b0, 0, 5, 5, 5, 5, 4'b1010);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_p0");
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, "p0");
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "p0_prd");
      hi += int'(prd_o);
    end
    checkValue("p0_prd_cnt", hi, 5);
    checkValue("p0_pwm", int'(pwm_o), 10);

    setConfig(1'b0, 1, 1, 0, 1, 0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_p1");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, "p1");
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "p1_prd");
      hi += int'(prd_o) + int'(cnt_o);
    end
    checkValue("p1_prd_cnt", hi, 5);

    // Reset in the middle of a running period.
    setConfig(1'b0, 10, 5, 0, 10, 3, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, "upd_pre_rst");
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, "pre_rst");
    applyReset("rst_mid", 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
